// File: rtl/tisc_bus_pkg.sv
// Shared definitions for the TISC register bus: data/address width,
// decoder state encoding and timeout counter sizing.
package tisc_bus_pkg;

  // Address and data width shared with the address-map generator.
  localparam int WIDTH = 32;

  // Default ACCESS timeout and the counter width it needs.
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int TMO_CNT_W = $clog2(DEFAULT_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ACCESS,
    RESP,
    WAIT_IDLE
  } state_t;

  // Counter width able to hold 0..cycles.
  function automatic int tmo_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/tisc_addr_match.sv
// Combinational address matcher: compares one address against every
// base/mask slot and reports all hits plus the lowest-index winner.
module tisc_addr_match
  import tisc_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [WIDTH-1:0]            adr_i,
  input  logic [WIDTH*NUM_SLAVES-1:0] base_i,
  input  logic [WIDTH*NUM_SLAVES-1:0] mask_i,
  output logic [NUM_SLAVES-1:0]       hit_o,
  output logic [NUM_SLAVES-1:0]       first_o,
  output logic [IDX_W-1:0]            idx_o
);

  // Walk slots from the top down so the lowest hitting index is written last.
  always_comb begin
    hit_o   = '0;
    first_o = '0;
    idx_o   = '0;
    for (int n = NUM_SLAVES - 1; n >= 0; n--) begin
      if ((adr_i & mask_i[n*WIDTH +: WIDTH]) ==
          (base_i[n*WIDTH +: WIDTH] & mask_i[n*WIDTH +: WIDTH])) begin
        hit_o[n]   = 1'b1;
        first_o    = '0;
        first_o[n] = 1'b1;
        idx_o      = IDX_W'(n);
      end
    end
  end

endmodule

// File: rtl/tisc_address_decoder.sv
// WISHBONE-classic address decoder for the TISC register space.
// Routes one master transaction to the lowest-index matching slave and
// returns ack/read data, or an error for unmapped addresses.
// Optional ACCESS timeout: define TISC_ADDRESS_DECODER_TIMEOUT_EN.
module tisc_address_decoder
  import tisc_bus_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [WIDTH*NUM_SLAVES-1:0] address_base_i,
  input  logic [WIDTH*NUM_SLAVES-1:0] address_mask_i,
  input  logic                        m_cyc_i,
  input  logic                        m_stb_i,
  input  logic                        m_we_i,
  input  logic [WIDTH-1:0]            m_adr_i,
  input  logic [WIDTH-1:0]            m_dat_i,
  output logic [WIDTH-1:0]            m_dat_o,
  output logic                        m_ack_o,
  output logic                        m_err_o,
  output logic [NUM_SLAVES-1:0]       s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  output logic                        s_we_o,
  output logic [WIDTH-1:0]            s_adr_o,
  output logic [WIDTH-1:0]            s_dat_o,
  input  logic [WIDTH*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]       s_ack_i
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("tisc_address_decoder: NUM_SLAVES and TIMEOUT_CYCLES must be >= 1");
  end

  logic [NUM_SLAVES-1:0] hit_c;
  logic [NUM_SLAVES-1:0] first_c;
  logic [IDX_W-1:0]      idx_c;

  tisc_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_match (
    .adr_i   (m_adr_i),
    .base_i  (address_base_i),
    .mask_i  (address_mask_i),
    .hit_o   (hit_c),
    .first_o (first_c),
    .idx_o   (idx_c)
  );

  state_t                state;
  logic [NUM_SLAVES-1:0] hit_q;
  logic [NUM_SLAVES-1:0] first_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      sel_idx;
  logic [WIDTH-1:0]      sel_rdat;
  logic                  sel_ack;

`ifdef TISC_ADDRESS_DECODER_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  // Only the selected slave's ack and data matter; strobe is one-hot on sel.
  assign sel_ack  = |(s_ack_i & s_stb_o);
  assign sel_rdat = s_dat_i[int'(sel_idx)*WIDTH +: WIDTH];

  // Transaction FSM; every master/slave output is registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      hit_q   <= '0;
      first_q <= '0;
      idx_q   <= '0;
      sel_idx <= '0;
      m_dat_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      s_cyc_o <= '0;
      s_stb_o <= '0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
`ifdef TISC_ADDRESS_DECODER_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      // Responses are single-cycle pulses.
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            s_adr_o <= m_adr_i;
            s_dat_o <= m_dat_i;
            s_we_o  <= m_we_i;
            // Snapshot the match so later map changes cannot move sel.
            hit_q   <= hit_c;
            first_q <= first_c;
            idx_q   <= idx_c;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (!m_cyc_i) begin
            state <= IDLE;
          end else if (|hit_q) begin
            sel_idx <= idx_q;
            s_cyc_o <= first_q;
            s_stb_o <= first_q;
`ifdef TISC_ADDRESS_DECODER_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state   <= ACCESS;
          end else begin
            m_err_o <= 1'b1;
            state   <= RESP;
          end
        end
        ACCESS: begin
          if (!m_cyc_i) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            state   <= IDLE;
          end else if (sel_ack) begin
            if (!s_we_o) m_dat_o <= sel_rdat;
            m_ack_o <= 1'b1;
            s_cyc_o <= '0;
            s_stb_o <= '0;
            state   <= RESP;
          end
`ifdef TISC_ADDRESS_DECODER_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            m_err_o <= 1'b1;
            s_cyc_o <= '0;
            s_stb_o <= '0;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          // Hold off until the master releases its strobe: one strobe, one response.
          if (!m_stb_i) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tisc_address_decoder.sv
// Self-checking bench for tisc_address_decoder: directed scenarios plus
// randomized transactions against a slot-matching reference model.
module tb_tisc_address_decoder;

  localparam int N = 4;
  localparam int W = 32;
`ifdef TISC_ADDRESS_DECODER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic             clk;
  logic             rst_i;
  logic [W*N-1:0]   address_base_i;
  logic [W*N-1:0]   address_mask_i;
  logic             m_cyc_i;
  logic             m_stb_i;
  logic             m_we_i;
  logic [W-1:0]     m_adr_i;
  logic [W-1:0]     m_dat_i;
  logic [W-1:0]     m_dat_o;
  logic             m_ack_o;
  logic             m_err_o;
  logic [N-1:0]     s_cyc_o;
  logic [N-1:0]     s_stb_o;
  logic             s_we_o;
  logic [W-1:0]     s_adr_o;
  logic [W-1:0]     s_dat_o;
  logic [W*N-1:0]   s_dat_i;
  logic [N-1:0]     s_ack_i;

  tisc_address_decoder #(
    .NUM_SLAVES     (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .address_base_i (address_base_i),
    .address_mask_i (address_mask_i),
    .m_cyc_i        (m_cyc_i),
    .m_stb_i        (m_stb_i),
    .m_we_i         (m_we_i),
    .m_adr_i        (m_adr_i),
    .m_dat_i        (m_dat_i),
    .m_dat_o        (m_dat_o),
    .m_ack_o        (m_ack_o),
    .m_err_o        (m_err_o),
    .s_cyc_o        (s_cyc_o),
    .s_stb_o        (s_stb_o),
    .s_we_o         (s_we_o),
    .s_adr_o        (s_adr_o),
    .s_dat_o        (s_dat_o),
    .s_dat_i        (s_dat_i),
    .s_ack_i        (s_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] base [N];
  logic [W-1:0] mask [N];
  logic [W-1:0] sdat [N];
  logic [W-1:0] exp_mdat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_map();
    for (int n = 0; n < N; n++) begin
      address_base_i[n*W +: W] = base[n];
      address_mask_i[n*W +: W] = mask[n];
      s_dat_i[n*W +: W]        = sdat[n];
    end
  endtask

  task automatic random_map();
    for (int n = 0; n < N; n++) begin
      base[n] = $urandom;
      if ($urandom_range(0, 9) == 0) mask[n] = '0;
      else mask[n] = 32'hFFFF_FFFF << $urandom_range(4, 28);
    end
    apply_map();
  endtask

  // Reference: first slot whose masked bits equal the masked address, else -1.
  function automatic int ref_slot(input logic [W-1:0] a);
    for (int n = 0; n < N; n++)
      if ((a & mask[n]) == (base[n] & mask[n])) return n;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full master transaction with cycle-exact checks.
  task automatic txn(input string tag, input logic [W-1:0] adr, input logic we,
                     input logic [W-1:0] wdat, input logic [W-1:0] rdat,
                     input int delay, input logic [N-1:0] noise, input bit scramble);
    int slot;
    logic [N-1:0] oh;
    slot = ref_slot(adr);
    oh = '0;
    if (slot >= 0) oh[slot] = 1'b1;
    m_adr_i = adr; m_we_i = we; m_dat_i = wdat;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    step();
    if (scramble) random_map();
    chk({tag, "_sadr"}, s_adr_o, adr);
    chk({tag, "_swe_sdat"}, {s_we_o, s_dat_o}, {we, wdat});
    chk({tag, "_decode_quiet"}, {m_ack_o, m_err_o, s_stb_o}, '0);
    step();
    if (slot < 0) begin
      chk({tag, "_err"}, {m_ack_o, m_err_o, s_cyc_o, s_stb_o}, {2'b01, {N{1'b0}}, {N{1'b0}}});
      step();
      chk({tag, "_err_pulse"}, {m_ack_o, m_err_o}, 2'b00);
    end else begin
      chk({tag, "_sel"}, {m_ack_o, m_err_o, s_cyc_o, s_stb_o}, {2'b00, oh, oh});
      for (int i = 0; i < delay; i++) begin
        s_ack_i = noise & ~oh;
        step();
        chk({tag, "_wait"}, {m_ack_o, m_err_o, s_stb_o}, {2'b00, oh});
      end
      for (int n = 0; n < N; n++) sdat[n] = $urandom;
      sdat[slot] = rdat;
      apply_map();
      s_ack_i = oh | noise;
      step();
      s_ack_i = '0;
      if (!we) exp_mdat = rdat;
      chk({tag, "_ack"}, {m_ack_o, m_err_o, s_cyc_o, s_stb_o}, {2'b10, {N{1'b0}}, {N{1'b0}}});
      chk({tag, "_mdat"}, m_dat_o, exp_mdat);
      step();
      chk({tag, "_ack_pulse"}, {m_ack_o, m_err_o}, 2'b00);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    step();
    chk({tag, "_idle"}, {m_ack_o, m_err_o, s_stb_o}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] oh;
    int k;
    bit seen;
    logic [W-1:0] a;
    int r;

    rst_i = 1'b1;
    m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_adr_i = '0; m_dat_i = '0;
    s_ack_i = '0;
    for (int n = 0; n < N; n++) begin base[n] = '0; mask[n] = '0; sdat[n] = '0; end
    apply_map();
    exp_mdat = '0;
    step(); step();
    chk("rst_ctrl", {m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o}, '0);
    chk("rst_data", {m_dat_o, s_adr_o}, '0);
    chk("rst_sdat", s_dat_o, '0);
    @(negedge clk); rst_i = 1'b0;
    step();

    // Directed map
    base[0] = 32'h0000_0000; mask[0] = 32'hFFFF_0000;
    base[1] = 32'h0001_0000; mask[1] = 32'hFFFF_0000;
    base[2] = 32'h4000_0000; mask[2] = 32'hF000_0000;
    base[3] = 32'h5000_0000; mask[3] = 32'hF000_0000;
    apply_map();

    txn("rd1", 32'h0001_0004, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, '0, 0);
    chk("rd1_const", m_dat_o, 32'hDEAD_BEEF);
    txn("wr0", 32'h0000_0010, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 1, '0, 0);
    chk("wr0_keep", m_dat_o, 32'hDEAD_BEEF);
    txn("unmapped", 32'h8000_0000, 1'b0, 32'h0, 32'h0, 0, '0, 0);

    // Overlapping slots 1 and 3; stray ack from slave 3 while waiting
    base[1] = 32'h0002_0000; mask[1] = 32'hFFFE_0000;
    base[3] = 32'h0002_0000; mask[3] = 32'hFFFF_0000;
    apply_map();
    txn("overlap", 32'h0002_0000, 1'b0, 32'h0, 32'h0BAD_F00D, 2, 4'b1000, 0);

    // Abort during second ACCESS cycle
    m_adr_i = 32'h0002_0000; m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    step(); step();
    chk("abort_acc1", s_stb_o, 4'b0010);
    step();
    chk("abort_acc2", {m_ack_o, m_err_o, s_stb_o}, {2'b00, 4'b0010});
    m_cyc_i = 1'b0;
    step();
    chk("abort_drop", {m_ack_o, m_err_o, s_cyc_o, s_stb_o}, '0);
    step();
    chk("abort_quiet", {m_ack_o, m_err_o, s_cyc_o, s_stb_o}, '0);
    m_stb_i = 1'b0;
    step();
    chk("abort_mdat", m_dat_o, exp_mdat);
    txn("after_abort", 32'h0002_0010, 1'b0, 32'h0, 32'h5555_AAAA, 0, '0, 0);

    // Long wait: timeout or indefinite ACCESS
    oh = 4'b0010;
    m_adr_i = 32'h0002_0000; m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    step(); step();
    chk("long_sel", s_stb_o, oh);
`ifdef TISC_ADDRESS_DECODER_TIMEOUT_EN
    k = 0; seen = 0;
    while (!m_err_o && k < 100) begin
      step();
      if (m_ack_o) seen = 1;
      k++;
    end
    chk("tmo_cycles", k, TMO);
    chk("tmo_err", {m_ack_o, m_err_o, s_stb_o, seen}, {2'b01, 4'b0000, 1'b0});
    s_ack_i = oh;
    step();
    s_ack_i = '0;
    chk("tmo_late_ack", {m_ack_o, m_err_o}, 2'b00);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    step();
    chk("tmo_idle", {m_ack_o, m_err_o, s_stb_o}, '0);
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (m_ack_o || m_err_o || s_stb_o != oh) seen = 1;
    end
    chk("noto_waiting", {seen, s_stb_o}, {1'b0, oh});
    sdat[1] = 32'h7777_1111;
    apply_map();
    s_ack_i = oh;
    step();
    s_ack_i = '0;
    exp_mdat = 32'h7777_1111;
    chk("noto_ack", {m_ack_o, m_err_o, m_dat_o}, {2'b10, exp_mdat});
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    step(); step();
`endif

    // Asynchronous reset mid-ACCESS
    m_adr_i = 32'h0002_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    step(); step();
    chk("rst_mid_sel", s_stb_o, 4'b0010);
    #2 rst_i = 1'b1;
    #1;
    exp_mdat = '0;
    chk("rst_mid_ctrl", {m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o}, '0);
    chk("rst_mid_data", {m_dat_o, s_adr_o}, '0);
    chk("rst_mid_sdat", s_dat_o, '0);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk); rst_i = 1'b0;
    step();

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      random_map();
      r = $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) < 7) a = (base[r] & mask[r]) | (W'($urandom) & ~mask[r]);
      else a = $urandom;
      txn("rnd", a, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3),
          N'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tisc_address_decoder.md
Name: tisc_address_decoder

Overview:
- Consumer end of the TISC address map.
- Takes the packed base/mask vectors produced by the address-map generator and decodes a single WISHBONE-classic master transaction to one of NUM_SLAVES slave ports.
- Returns the slave's ack and read data to the master. Unmapped addresses get an error response.
- Sits between the host register bus (PCIe/serial bridge) and the TISC register-space slaves.

Parameters:
- NUM_SLAVES, 4, number of decoded slave ports; must be at least 1.
- WIDTH, 32, address/data width; taken from the shared package and must match the address map.
- TIMEOUT_CYCLES, 255, maximum cycles spent in ACCESS before an error is returned (used only with the optional feature).

Ports:
- clk_i  in  1  single clock for the whole block.
- rst_i  in  1  asynchronous, active-high reset.
- address_base_i  in  WIDTH*NUM_SLAVES  slot n base address at [n*WIDTH +: WIDTH].
- address_mask_i  in  WIDTH*NUM_SLAVES  slot n compare mask (1 = bit is compared).
- m_cyc_i  in  1  master cycle.
- m_stb_i  in  1  master strobe.
- m_we_i  in  1  master write enable.
- m_adr_i  in  WIDTH  master address.
- m_dat_i  in  WIDTH  master write data.
- m_dat_o  out  WIDTH  read data to master.
- m_ack_o  out  1  master acknowledge.
- m_err_o  out  1  master error (unmapped address or timeout).
- s_cyc_o  out  NUM_SLAVES  per-slave cycle, one-hot.
- s_stb_o  out  NUM_SLAVES  per-slave strobe, one-hot.
- s_we_o  out  1  shared write enable.
- s_adr_o  out  WIDTH  shared address, registered.
- s_dat_o  out  WIDTH  shared write data, registered.
- s_dat_i  in  WIDTH*NUM_SLAVES  slave read data, packed like the base vector.
- s_ack_i  in  NUM_SLAVES  slave acks.

Behaviour:
- Reset (async, rst_i=1): all outputs 0, state IDLE, sel=0, timeout counter 0.
- Match rule: slot n hits when (m_adr & mask[n]) == (base[n] & mask[n]).
  - Mask 0 matches every address.
  - If several slots hit, the lowest index wins.
- IDLE:
  - On m_cyc_i & m_stb_i, register adr/dat/we into s_adr_o/s_dat_o/s_we_o.
  - Register the hit vector; go to DECODE.
- DECODE (1 cycle):
  - Any hit: sel = lowest hit index; go to ACCESS.
  - No hit: go to RESP with err.
- ACCESS:
  - s_cyc_o[sel] = s_stb_o[sel] = 1; all other bits 0.
  - On s_ack_i[sel]: capture s_dat_i[sel] into m_dat_o (reads; writes leave m_dat_o unchanged), drop the strobes, go to RESP with ack.
  - Acks from non-selected slaves are ignored.
- RESP: m_ack_o or m_err_o high for exactly 1 cycle, then go to WAIT_IDLE.
- WAIT_IDLE: stay until m_stb_i=0, so one strobe yields exactly one response; then go to IDLE.
- Latency: request seen at cycle 0, DECODE at 1, ACCESS from 2. A slave acking in its first ACCESS cycle gives m_ack_o at cycle 3. Unmapped address gives m_err_o at cycle 2.
- Abort: m_cyc_i=0 in DECODE/ACCESS means
  - drop all s_cyc/s_stb next cycle;
  - go to IDLE with no m_ack/m_err.
- m_ack_o and m_err_o are never high together.
- s_cyc_o/s_stb_o are always one-hot or zero.
- Address/mask changes mid-transaction do not affect the latched sel.

Optional Feature:
- Macro: TISC_ADDRESS_DECODER_TIMEOUT_EN.
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle.
  - Reaching TIMEOUT_CYCLES with no ack: drop the strobes, go to RESP with m_err_o.
  - A late slave ack after timeout is ignored.
- Undefined: no counter logic; ACCESS waits indefinitely for s_ack_i[sel].

Decomposition:
- Package tisc_bus_pkg holds:
  - WIDTH=32 localparam;
  - state enum {IDLE, DECODE, ACCESS, RESP, WAIT_IDLE};
  - timeout counter width constant, $clog2(TIMEOUT_CYCLES+1).
- Sub-module tisc_addr_match: combinational, parameterized by NUM_SLAVES.
  - Outputs: hit vector, lowest-index one-hot, and encoded index.
  - Instantiated once; the decoder registers its outputs in DECODE.

Test Plan:
- Slot0 base 0x00000000 mask 0xFFFF0000, slot1 base 0x00010000 mask 0xFFFF0000. Read 0x00010004, slave1 acks in first ACCESS cycle with 0xDEADBEEF → s_stb_o=4'b0010, m_ack_o at cycle 3, m_dat_o=0xDEADBEEF.
- Write 0x00000010 data 0x12345678 → s_stb_o=4'b0001, s_we_o=1, s_dat_o=0x12345678; m_ack_o pulses once; m_dat_o unchanged.
- Address 0x80000000 with no slot matching → no slave strobe, m_err_o=1 at cycle 2 for 1 cycle, m_ack_o=0.
- Slots 1 and 3 both match 0x00020000 → slave1 selected; s_ack_i[3] pulsed during ACCESS is ignored.
- m_cyc_i dropped in 2nd ACCESS cycle → s_stb_o=0 next cycle, no ack/err. A new request afterwards completes normally.
- TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never acks → m_err_o after 8 ACCESS cycles. Without the macro, still in ACCESS after 1000 cycles. rst_i asserted mid-ACCESS → all outputs 0 immediately.
